// File: rtl/stereo_i2s_tx_pkg.sv
// -----------------------------------------------------------------------------
// stereo_i2s_tx_pkg
// Shared audio constants and helpers for the stereo I2S transmitter.
//   SAMPLE_W         bits per channel sample
//   SLOTS_PER_CH     SCLK slots per channel half-frame (lrck low / high)
//   DATA_START_SLOT  I2S one-slot delay: first data bit lands in this slot
//   slot_sel()       tells which channel, if any, owns the bit of a given slot
// -----------------------------------------------------------------------------
package stereo_i2s_tx_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int SLOTS_PER_CH    = 32;
  localparam int DATA_START_SLOT = 1;

  localparam int SLOTS_PER_FRAME = 2 * SLOTS_PER_CH;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Source of the serial bit for one slot.
  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2
  } bit_sel_e;

  // The upper slot bit is the channel (it equals lrck); the lower bits are the
  // position inside the channel. Data occupies SAMPLE_W slots starting at
  // DATA_START_SLOT, everything else in the half-frame is padding zeros.
  function automatic bit_sel_e slot_sel(input logic [SLOT_W-1:0] slot);
    int ofs;
    ofs = 32'(slot[SLOT_W-2:0]);
    if (ofs >= DATA_START_SLOT && ofs < DATA_START_SLOT + SAMPLE_W)
      return slot[SLOT_W-1] ? SEL_RIGHT : SEL_LEFT;
    return SEL_ZERO;
  endfunction

endpackage

// File: rtl/stereo_i2s_tx_if.sv
// -----------------------------------------------------------------------------
// stereo_i2s_tx_if
// Timing bundle between the clock/frame generator and the data path.
//   mclk, sclk, lrck  registered DAC clock pins
//   wrap              one-cycle strobe, high while the frame counter sits at 0
//                     after wrapping (never in the first frame after reset)
//   slot_end          one-cycle strobe on the last clk of every slot
//   slot              current slot index 0..63
// Handshake: there is no back-pressure. The master drives every signal from
// flops each cycle; the slave samples them on the same rising edge and must
// act on a strobe in the single cycle it is high.
// -----------------------------------------------------------------------------
interface stereo_i2s_tx_if;
  import stereo_i2s_tx_pkg::*;

  logic              mclk;
  logic              sclk;
  logic              lrck;
  logic              wrap;
  logic              slot_end;
  logic [SLOT_W-1:0] slot;

  modport master (output mclk, sclk, lrck, wrap, slot_end, slot);
  modport slave  (input  mclk, sclk, lrck, wrap, slot_end, slot);

endinterface

// File: rtl/stereo_i2s_tx_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Free-running frame counter and I2S clock generation.
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   clk_if    master side of the timing bundle (pins, wrap, slot_end, slot)
// The frame counter fcnt = slot*SCLK_DIV + scnt is kept as two fields so that
// no divider is needed for non-power-of-two SCLK_DIV. SCLK_DIV must be a
// multiple of 8 and at least 8.
// Every pin is a flop loaded from the *next* counter value, so the pins are
// always consistent with the counter value currently held.
// -----------------------------------------------------------------------------
module i2s_clkgen
  import stereo_i2s_tx_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  stereo_i2s_tx_if.master   clk_if
);

  localparam int MDIV   = SCLK_DIV / 8;
  localparam int SCNT_W = $clog2(SCLK_DIV);
  localparam int MCNT_W = (MDIV > 1) ? $clog2(MDIV) : 1;

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCLK_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(SCLK_DIV / 2);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MDIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_FRAME - 1);

  logic [SCNT_W-1:0] scnt;
  logic [SCNT_W-1:0] scnt_nxt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic [MCNT_W-1:0] mcnt;
  logic [MCNT_W-1:0] mcnt_nxt;
  logic              scnt_last;
  logic              mcnt_last;

  logic mclk_q;
  logic sclk_q;
  logic lrck_q;
  logic wrap_q;
  logic slot_end_q;

  always_comb begin
    scnt_last = (scnt == SCNT_LAST);
    scnt_nxt  = scnt_last ? '0 : scnt + SCNT_W'(1);
    // slot is exactly SLOT_W bits wide, so 63 -> 0 wraps naturally
    slot_nxt  = scnt_last ? slot + SLOT_W'(1) : slot;
    mcnt_last = (mcnt == MCNT_LAST);
    mcnt_nxt  = mcnt_last ? '0 : mcnt + MCNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt       <= '0;
      slot       <= '0;
      mcnt       <= '0;
      mclk_q     <= 1'b0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      wrap_q     <= 1'b0;
      slot_end_q <= 1'b0;
    end else begin
      scnt       <= scnt_nxt;
      slot       <= slot_nxt;
      mcnt       <= mcnt_nxt;
      // MDIV divides SCLK_DIV/2, so mclk edges stay phase-locked to sclk
      if (mcnt_last) mclk_q <= ~mclk_q;
      sclk_q     <= (scnt_nxt >= SCNT_HALF);
      lrck_q     <= slot_nxt[SLOT_W-1];
      wrap_q     <= scnt_last && (slot == SLOT_LAST);
      slot_end_q <= (scnt_nxt == SCNT_LAST);
    end
  end

  assign clk_if.mclk     = mclk_q;
  assign clk_if.sclk     = sclk_q;
  assign clk_if.lrck     = lrck_q;
  assign clk_if.wrap     = wrap_q;
  assign clk_if.slot_end = slot_end_q;
  assign clk_if.slot     = slot;

endmodule

// File: rtl/stereo_i2s_tx.sv
// -----------------------------------------------------------------------------
// stereo_i2s_tx
// Stereo 16-bit I2S transmitter, 32 SCLK slots per channel, one-slot delay.
//   clk, reset_n           clock and asynchronous active-low reset
//   sample_l, sample_r     signed samples, captured when sample_valid=1
//   sample_valid           capture strobe; last one in a frame wins
//   mute                   sampled only at frame start; 1 = send zeros
//   sample_req             one-cycle pulse at each frame start
//   underrun               one-cycle pulse at frame start if nothing new arrived
//   mclk, sclk, lrck, sdin DAC pins, all driven straight from flops
// Samples land in hold registers; at frame start (wrap) the hold values move
// to the shift registers, so a capture in the wrap cycle itself goes to the
// following frame. Without a new capture the old hold values are sent again.
// -----------------------------------------------------------------------------
module stereo_i2s_tx
  import stereo_i2s_tx_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  input  logic                mute,
  output logic                sample_req,
  output logic                underrun,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdin
);

  stereo_i2s_tx_if clk_if ();

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_if  (clk_if)
  );

  sample_t           hold_l;
  sample_t           hold_r;
  sample_t           shift_l;
  sample_t           shift_r;
  logic              pending;
  logic              sdin_q;
  logic              underrun_q;

  logic [SLOT_W-1:0] slot_next;
  bit_sel_e          next_sel;
  logic              frame_end;

  always_comb begin
    slot_next = clk_if.slot + SLOT_W'(1);
    next_sel  = slot_sel(slot_next);
    // last clk of slot 63: the following cycle is the wrap cycle
    frame_end = clk_if.slot_end && (clk_if.slot == SLOT_W'(SLOTS_PER_FRAME - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l     <= '0;
      hold_r     <= '0;
      shift_l    <= '0;
      shift_r    <= '0;
      pending    <= 1'b0;
      sdin_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // Capture path: newest valid always overwrites the hold registers.
      if (sample_valid) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end

      // pending tracks "a sample arrived for the next frame"; a valid in the
      // wrap cycle itself counts for the frame after the one starting now.
      if (clk_if.wrap) pending <= sample_valid;
      else if (sample_valid) pending <= 1'b1;

      // The pending value the wrap cycle will see includes a valid in the
      // last cycle of the frame, hence the OR with sample_valid.
      underrun_q <= frame_end && !(pending || sample_valid);

      // Shift registers: loaded at wrap (old hold values, nonblocking), then
      // one bit per slot. sdin is updated on the last clk of a slot so it
      // changes together with the sclk falling edge.
      if (clk_if.wrap) begin
        shift_l <= mute ? '0 : hold_l;
        shift_r <= mute ? '0 : hold_r;
      end else if (clk_if.slot_end) begin
        case (next_sel)
          SEL_LEFT: begin
            sdin_q  <= shift_l[SAMPLE_W-1];
            shift_l <= {shift_l[SAMPLE_W-2:0], 1'b0};
          end
          SEL_RIGHT: begin
            sdin_q  <= shift_r[SAMPLE_W-1];
            shift_r <= {shift_r[SAMPLE_W-2:0], 1'b0};
          end
          default: sdin_q <= 1'b0;
        endcase
      end
    end
  end

  assign sample_req = clk_if.wrap;
  assign underrun   = underrun_q;
  assign mclk       = clk_if.mclk;
  assign sclk       = clk_if.sclk;
  assign lrck       = clk_if.lrck;
  assign sdin       = sdin_q;

endmodule

// File: tb/tb_stereo_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_stereo_i2s_tx
// Bench for stereo_i2s_tx with SCLK_DIV=8 (frame = 512 clk).
// Inputs are driven on the falling edge; pins are sampled on the falling edge
// before new inputs are applied. The reference model works on frame position
// arithmetic and per-frame words; decoded frames go through an expected queue.
// -----------------------------------------------------------------------------
module tb_stereo_i2s_tx;
  import stereo_i2s_tx_pkg::*;

  localparam int SCLK_DIV = 8;
  localparam int FRAME    = 64 * SCLK_DIV;
  localparam logic [63:0] DATA_MASK = 64'h7FFF8000_7FFF8000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_req;
  logic        underrun;
  logic        sdin;

  // Pin bundle: DUT clock pins plus the bench's own expected frame timing.
  stereo_i2s_tx_if pin_if ();
  logic              tb_wrap = 1'b0;
  logic              tb_slot_end = 1'b0;
  logic [SLOT_W-1:0] tb_slot = '0;
  assign pin_if.wrap     = tb_wrap;
  assign pin_if.slot_end = tb_slot_end;
  assign pin_if.slot     = tb_slot;

  stereo_i2s_tx #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .mute         (mute),
    .sample_req   (sample_req),
    .underrun     (underrun),
    .mclk         (pin_if.mclk),
    .sclk         (pin_if.sclk),
    .lrck         (pin_if.lrck),
    .sdin         (sdin)
  );

  // ---------------- scoreboard / model state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;
  logic [31:0] exp_q[$];
  logic [15:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
  logic        m_pending;
  logic [63:0] rx_bits;
  logic        prev_sclk, prev_sdin;

  int frame_no = 0;
  int cur_frame = 0;
  int v_pos1, v_pos2, mute_pos;
  logic mute_lvl;
  logic [15:0] d1l, d1r, d2l, d2r;
  logic [15:0] a_l, a_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_pins_zero(input string tag);
    check({tag, "_mclk"}, 32'(pin_if.mclk), 0);
    check({tag, "_sclk"}, 32'(pin_if.sclk), 0);
    check({tag, "_lrck"}, 32'(pin_if.lrck), 0);
    check({tag, "_sdin"}, 32'(sdin), 0);
    check({tag, "_req"},  32'(sample_req), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  // ---------------- stimulus plan per frame ----------------
  task automatic plan_frame();
    v_pos1 = -1; v_pos2 = -1; mute_pos = -1; mute_lvl = mute;
    d1l = 16'($urandom); d1r = 16'($urandom);
    d2l = 16'($urandom); d2r = 16'($urandom);
    case (frame_no)
      0: begin v_pos1 = 100; d1l = 16'h8001; d1r = 16'h7FFE; end
      1: begin v_pos1 = 200; a_l = d1l; a_r = d1r; end
      2: ;                                          // no sample: underrun next
      3: begin v_pos1 = 0; d1l = 16'h1234; d1r = 16'h1234; end
      4: begin v_pos1 = 300; mute_pos = 250; mute_lvl = 1'b1; end
      5: begin v_pos1 = 10; v_pos2 = 400; mute_pos = 100; mute_lvl = 1'b0; end
      default: begin
        case ($urandom_range(0, 3))
          0: ;
          1: v_pos1 = $urandom_range(0, FRAME - 1);
          2: begin v_pos1 = $urandom_range(0, 255); v_pos2 = $urandom_range(256, FRAME - 1); end
          default: v_pos1 = 0;
        endcase
        if ($urandom_range(0, 3) == 0) begin
          mute_pos = $urandom_range(1, FRAME - 1);
          mute_lvl = ~mute;
        end
      end
    endcase
    cur_frame = frame_no;
    frame_no++;
  endtask

  task automatic model_reset();
    n = 1;
    m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0;
    m_pending = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);       // first frame after reset carries zeros
    rx_bits = '0;
    prev_sclk = 1'b0;
    prev_sdin = 1'b0;
    plan_frame();
  endtask

  // ---------------- one clk period: check, decode, drive, model ----------------
  task automatic run_period();
    int fpos, slot;
    logic is_wrap, exp_sdin;
    logic [31:0] w;
    @(negedge clk);
    fpos = n % FRAME;
    slot = fpos / SCLK_DIV;
    is_wrap = (fpos == 0) && (n > 0);
    tb_wrap = is_wrap;
    tb_slot = SLOT_W'(slot);
    tb_slot_end = ((fpos % SCLK_DIV) == SCLK_DIV - 1);

    check("mclk", 32'(pin_if.mclk), 32'((fpos / (SCLK_DIV / 8)) % 2));
    check("sclk", 32'(pin_if.sclk), 32'((fpos % SCLK_DIV) >= SCLK_DIV / 2));
    check("lrck", 32'(pin_if.lrck), 32'(slot >= 32));
    check("sample_req", 32'(sample_req), 32'(is_wrap));
    check("underrun", 32'(underrun), 32'(is_wrap && !m_pending));
    exp_sdin = 1'b0;
    if (slot >= 1 && slot <= 16) exp_sdin = m_cur_l[16 - slot];
    else if (slot >= 33 && slot <= 48) exp_sdin = m_cur_r[48 - slot];
    check("sdin", 32'(sdin), 32'(exp_sdin));
    if (prev_sclk && pin_if.sclk) check("sdin_hold", 32'(sdin), 32'(prev_sdin));

    // Decode on sclk rising edges, slot 0 stored at bit 63.
    if (pin_if.sclk && !prev_sclk) rx_bits[63 - slot] = sdin;
    if (fpos == FRAME - 1) begin
      if (exp_q.size() == 0) begin
        check("frame_q_empty", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("frame_l", 32'(rx_bits[62:47]), 32'(w[31:16]));
        check("frame_r", 32'(rx_bits[30:15]), 32'(w[15:0]));
        check("frame_gap", 32'(|(rx_bits & ~DATA_MASK)), 0);
        if (cur_frame == 1) begin
          check("l_8001", 32'(rx_bits[62:47]), 32'h8001);
          check("r_7ffe", 32'(rx_bits[30:15]), 32'h7FFE);
        end
        if (cur_frame == 3) begin
          check("retx_l", 32'(rx_bits[62:47]), 32'(a_l));
          check("retx_r", 32'(rx_bits[30:15]), 32'(a_r));
        end
        if (cur_frame == 4) check("wrap_valid_l", 32'(rx_bits[62:47]), 32'h1234);
        if (cur_frame == 5) check("muted", 32'(rx_bits[62:15]), 0);
      end
      rx_bits = '0;
    end

    // Drive inputs for this period.
    if (fpos == 0) plan_frame();
    sample_valid = (fpos == v_pos1) || (fpos == v_pos2);
    if (fpos == v_pos1) begin sample_l = d1l; sample_r = d1r; end
    else if (fpos == v_pos2) begin sample_l = d2l; sample_r = d2r; end
    else begin sample_l = 16'($urandom); sample_r = 16'($urandom); end
    if (fpos == mute_pos) mute = mute_lvl;

    // Reference model: frame start takes the hold words (or zeros if muted).
    if (is_wrap) begin
      m_cur_l = mute ? 16'h0 : m_hold_l;
      m_cur_r = mute ? 16'h0 : m_hold_r;
      exp_q.push_back({m_cur_l, m_cur_r});
      m_pending = sample_valid;
    end else if (sample_valid) begin
      m_pending = 1'b1;
    end
    if (sample_valid) begin m_hold_l = sample_l; m_hold_r = sample_r; end

    prev_sclk = pin_if.sclk;
    prev_sdin = sdin;
    n++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (10) begin
      @(negedge clk);
      check_pins_zero("rst");
    end
    reset_n = 1'b1;
    model_reset();

    while (n < 12 * FRAME + 300) run_period();

    // Mid-frame reset: pins must drop without waiting for a clock edge.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_pins_zero("async_rst");
    repeat (10) begin
      @(negedge clk);
      check_pins_zero("rst2");
    end
    sample_valid = 1'b0;
    mute = 1'b0;
    reset_n = 1'b1;
    model_reset();

    while (n < 2 * FRAME + 40) run_period();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stereo_i2s_tx.md
STEREO_I2S_TX -- requirements
Module: stereo_i2s_tx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 32, meaning clk cycles per SCLK period; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port sample_l, input, 16 bits: signed two's-complement left sample, from the stereo conditioner.
REQ-005 SHALL have port sample_r, input, 16 bits: signed two's-complement right sample.
REQ-006 SHALL have port sample_valid, input, 1 bit: sample_l/sample_r are valid this cycle.
REQ-007 SHALL have port mute, input, 1 bit: transmit zeros from the next frame onward.
REQ-008 SHALL have port sample_req, output, 1 bit: one-cycle pulse at each frame start, requesting the next sample.
REQ-009 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts with no new sample captured.
REQ-010 SHALL have ports mclk, sclk, lrck and sdin, outputs, 1 bit each: the I2S DAC pins.

Function
REQ-011 SHALL run a free-running frame counter fcnt over 0..64*SCLK_DIV-1, wrapping to 0.
REQ-012 SHALL derive the slot index slot = fcnt / SCLK_DIV, range 0..63.
REQ-013 SHALL drive sclk low for the first SCLK_DIV/2 cycles of each slot and high for the rest.
REQ-014 SHALL toggle mclk every SCLK_DIV/8 cycles, so mclk = 4*sclk and mclk/lrck = 256.
REQ-015 SHALL drive lrck 0 for slots 0-31 (left) and 1 for slots 32-63 (right).
REQ-016 SHALL drive sdin per I2S with a one-slot delay: slot 0 is 0; slots 1-16 carry left bits 15..0, MSB first; slots 17-31 are 0.
REQ-017 SHALL drive sdin for the right channel identically at slots 32, 33-48 and 49-63.
REQ-018 SHALL change sdin only at slot start, i.e. on the sclk falling edge, and hold it stable while sclk is high.
REQ-019 SHALL register all pin outputs with no combinational path from any input to any pin.
REQ-020 SHALL capture sample_l/sample_r into hold registers and set a pending flag whenever sample_valid=1; a later valid within the same frame overwrites the earlier one.
REQ-021 SHALL, on the cycle fcnt wraps to 0, load both hold registers into the transmit shift registers and clear the pending flag; if mute=1 it loads zeros instead.
REQ-022 SHALL assert sample_req for exactly one cycle on that same wrap cycle.
REQ-023 SHALL pulse underrun on the wrap cycle if the pending flag was 0, then retransmit the previous hold values.
REQ-024 SHALL, when sample_valid coincides with the wrap cycle, load the old hold values into the shift registers and give the new sample to the next frame, with no underrun pulse in the following frame.
REQ-025 SHALL sample mute only at the wrap cycle, never mid-frame.
REQ-026 SHALL give latency from sample capture to first MSB on sdin of at most one frame plus one slot.

Reset
REQ-027 SHALL, while reset_n=0, hold fcnt=0, hold and shift registers at 0, pending=0, and mclk, sclk, lrck, sdin, sample_req and underrun all at 0.
REQ-028 SHALL start the first frame at fcnt=0 after reset release; that frame transmits zeros and raises no sample_req or underrun.
REQ-029 SHALL abandon the frame when reset is asserted mid-frame, with pins going low immediately and asynchronously.

Structure
REQ-030 SHALL place SAMPLE_W=16, SLOTS_PER_CH=32 and DATA_START_SLOT=1 in the shared audio package.
REQ-031 SHALL implement the counter, mclk, sclk and lrck in one sub-module, i2s_clkgen, which outputs a wrap strobe and the slot index.

Verification (SCLK_DIV=8, frame = 512 clk)
REQ-032 SHALL cover reset: reset_n=0 for 10 cycles, then released -> all outputs 0 during reset; lrck rises at clk 256; first sample_req at clk 512.
REQ-033 SHALL cover serial data: sample_l=0x8001, sample_r=0x7FFE, valid before the wrap -> decoding sdin on sclk rising edges yields L=0x8001 and R=0x7FFE in the next frame, with slots 0 and 17-31 equal to 0.
REQ-034 SHALL cover underrun: no valid for one frame -> underrun pulses once at the wrap and the previous L/R is retransmitted unchanged.
REQ-035 SHALL cover valid at wrap: sample_valid coincident with the wrap cycle, value 0x1234 -> current frame carries the old value, next frame carries 0x1234, and no underrun.
REQ-036 SHALL cover mute: mute=1 asserted mid-frame -> the current frame is unchanged and the next frame's sdin is all 0; mute=0 -> data resumes at the following wrap.
REQ-037 SHALL cover clock ratios: mclk toggles every cycle, sclk period is 8 cycles, lrck period is 512 cycles, and sdin never changes while sclk=1.
